// File: rtl/decode_pkg.sv
// Shared defaults and types for the decode-stage register file and scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package decode_pkg;

  localparam int DEF_XLEN  = 64;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NREAD = 2;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] xlen_t;

  // x0: reads as zero, never written, never busy
  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/decode_sb_popcnt.sv
// Population count of the scoreboard busy vector.
// Latency: combinational.
// Backpressure: none.
module decode_sb_popcnt
  import decode_pkg::*;
#(
  parameter int  N = DEF_NREGS,
  localparam int W = $clog2(N) + 1
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] cnt_o
);

  // Plain ripple sum; N is small enough that synthesis builds a good adder tree.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N; i++) begin
      cnt_o = cnt_o + W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/decode_regfile_sb.sv
// Register file with NREAD combinational read ports, one write-back port and a busy scoreboard.
// Latency: reads 0 cycles (write-back bypassed); writes and busy updates take effect at the next edge.
// Backpressure: iss_ready drops while the claimed destination is busy, unless it retires this cycle.
module decode_regfile_sb
  import decode_pkg::*;
#(
  parameter int  XLEN  = DEF_XLEN,
  parameter int  NREGS = DEF_NREGS,
  parameter int  NREAD = DEF_NREAD,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  output logic                  iss_ready,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  output logic [AW:0]           busy_cnt
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW:0]      busy_cnt_q;
  logic [AW:0]      busy_cnt_d;
  logic             wb_en;
  logic             iss_fire;

  assign wb_en = wb_valid && (wb_addr != '0);

  // WAW stall: a busy destination is only released by a write-back to it in the same cycle.
  assign iss_ready = !busy_q[iss_rd] || (wb_valid && (wb_addr == iss_rd)) || (iss_rd == '0);

  // A flush discards the claim made in the same cycle.
  assign iss_fire = iss_valid && iss_ready && (iss_rd != '0) && !flush;

  // Next busy vector: flush clears everything, otherwise clear-then-set so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wb_en) begin
        busy_d[wb_addr] = 1'b0;
      end
      if (iss_fire) begin
        busy_d[iss_rd] = 1'b1;
      end
    end
  end

  decode_sb_popcnt #(
    .N (NREGS)
  ) u_popcnt (
    .vec_i (busy_d),
    .cnt_o (busy_cnt_d)
  );

  // Scoreboard state; count is registered together with the vector it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Register storage; write-back updates data even during a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wb_en) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  assign busy_cnt = busy_cnt_q;

  // Read ports: x0 reads zero, a same-cycle write-back is forwarded and reported not busy.
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit_wb;
    assign addr   = rd_addr[i*AW +: AW];
    assign hit_wb = wb_en && (wb_addr == addr);
    assign rd_data[i*XLEN +: XLEN] = (addr == '0) ? '0 :
                                     hit_wb        ? wb_data : regs_q[addr];
    assign rd_busy[i] = (addr != '0) && !hit_wb && busy_q[addr];
  end

endmodule
